// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: sends WIDTH-bit words MSB first with zero-gap back-to-back frames.
// Optional even-parity bit after each word when PISO_PARITY_EN is defined.
module piso_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             valid,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PISO_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             sout_q;
    logic             valid_q;
    logic             done_q;
    logic             ready_q;
    logic             accept;
    logic             done_at_next;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    assign accept = load && ready_q;

    // The next bit-time is the frame's last only when no parity bit follows the data.
`ifdef PISO_PARITY_EN
    assign done_at_next = 1'b0;
`else
    assign done_at_next = (cnt_q == PENULT_BIT);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (accept) begin
            state_q <= SHIFT;
            shreg_q <= din;
            cnt_q   <= '0;
            sout_q  <= din[WIDTH-1];
            valid_q <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= ^din;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
                        state_q <= PARITY;
                        sout_q  <= par_q;
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
`else
                        state_q <= IDLE;
                        sout_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
`endif
                    end else begin
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q + CW'(1);
                        sout_q  <= shreg_q[WIDTH-2];
                        valid_q <= 1'b1;
                        done_q  <= done_at_next;
                        ready_q <= done_at_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign sout  = sout_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx (WIDTH=8): per-edge vector table plus loopback and timeout-bounded sequences.
module tb_piso_tx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load;
    logic         ready;
    logic         sout;
    logic         valid;
    logic         done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] din;
        logic         ready;
        logic         valid;
        logic         sout;
        logic         done;
    } vec_t;

    vec_t vecs[$];

    piso_tx #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .load (load),
        .ready(ready),
        .sout (sout),
        .valid(valid),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic [W-1:0] d,
                       input logic er, input logic ev, input logic es, input logic ed);
        vec_t v;
        v.rst = r; v.load = l; v.din = d;
        v.ready = er; v.valid = ev; v.sout = es; v.done = ed;
        vecs.push_back(v);
    endtask

    // One data bit per edge of a frame without reload; the last bit carries done/ready.
    task automatic add_frame_tail(input logic [W-1:0] word, input logic [W-1:0] d_drive);
        for (int b = W - 2; b >= 0; b--)
            add(1'b1, 1'b0, d_drive, (b == 0), 1'b1, word[b], (b == 0));
    endtask

    task automatic step(input logic r, input logic l, input logic [W-1:0] d);
        @(negedge clk);
        rst = r; load = l; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] word;
        int           done_cnt;
        int           waited;

        rst = 1'b0; load = 1'b0; din = '0;

        // Reset, reset release
        add(1'b0, 1'b0, 8'h00, 1, 0, 0, 0);
        add(1'b0, 1'b0, 8'h00, 1, 0, 0, 0);
        add(1'b1, 1'b0, 8'h00, 1, 0, 0, 0);
`ifndef PISO_PARITY_EN
        // B2 from idle, then idle
        add(1'b1, 1'b1, 8'hB2, 0, 1, 1, 0);
        add_frame_tail(8'hB2, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1, 0, 0, 0);
        // A5 then 3C back-to-back, reload in A5's last bit-time
        add(1'b1, 1'b1, 8'hA5, 0, 1, 1, 0);
        add_frame_tail(8'hA5, 8'h00);
        add(1'b1, 1'b1, 8'h3C, 0, 1, 0, 0);
        add_frame_tail(8'h3C, 8'h55);
        add(1'b1, 1'b0, 8'h55, 1, 0, 0, 0);
        // 00 frame with FF load attempted mid-frame
        add(1'b1, 1'b1, 8'h00, 0, 1, 0, 0);
        add(1'b1, 1'b1, 8'hFF, 0, 1, 0, 0);
        for (int b = W - 3; b >= 0; b--)
            add(1'b1, 1'b0, 8'hFF, (b == 0), 1'b1, 1'b0, (b == 0));
        add(1'b1, 1'b0, 8'hFF, 1, 0, 0, 0);
        add(1'b1, 1'b0, 8'hFF, 1, 0, 0, 0);
        // C3 aborted by reset (with simultaneous load) in bit-time 4
        add(1'b1, 1'b1, 8'hC3, 0, 1, 1, 0);
        add(1'b1, 1'b0, 8'h00, 0, 1, 1, 0);
        add(1'b1, 1'b0, 8'h00, 0, 1, 0, 0);
        add(1'b1, 1'b0, 8'h00, 0, 1, 0, 0);
        add(1'b0, 1'b1, 8'hE7, 1, 0, 0, 0);
        add(1'b1, 1'b0, 8'h00, 1, 0, 0, 0);
        add(1'b1, 1'b0, 8'h00, 1, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].din);
            chk($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].ready));
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d_sout", i), 32'(sout), 32'(vecs[i].sout));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
        end

        // Loopback into a left-shifting SIPO, din changing mid-frame
`ifdef PISO_PARITY_EN
        word = 8'h07;
`else
        word = 8'h5A;
`endif
        q = '0;
        done_cnt = 0;
        step(1'b1, 1'b1, word);
        for (int e = 0; e < int'(W); e++) begin
            q = {q[W-2:0], sout};
            if (done) done_cnt++;
            chk($sformatf("lb_valid%0d", e), 32'(valid), 32'd1);
            if (e < int'(W) - 1) step(1'b1, 1'b0, ~word);
        end
        chk("lb_sipo", 32'(q), 32'(word));
`ifdef PISO_PARITY_EN
        chk("lb_done_early", 32'(done_cnt), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("par_bit", 32'(sout), 32'(^word));
        chk("par_valid", 32'(valid), 32'd1);
        chk("par_done", 32'(done), 32'd1);
        chk("par_ready", 32'(ready), 32'd1);
`else
        chk("lb_done", 32'(done_cnt), 32'd1);
`endif
        step(1'b1, 1'b0, 8'h00);
        chk("lb_idle_valid", 32'(valid), 32'd0);
        chk("lb_idle_done", 32'(done), 32'd0);

        // Bounded wait for ready after a fresh load
        step(1'b1, 1'b1, 8'h81);
        load = 1'b0;
        waited = 0;
        while (!ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
`ifdef PISO_PARITY_EN
        chk("ready_latency", 32'(waited), 32'(W));
`else
        chk("ready_latency", 32'(waited), 32'(W - 1));
`endif
        chk("ready_last_sout", 32'(sout), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
